// File: rtl/iterative_prefix_adder_ctrl_if.sv
// Operand/result handshake bundle for the iterative prefix adder.
// The producer/consumer side uses the master modport; the adder uses slave.
interface iterative_prefix_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/iterative_prefix_adder_ctrl.sv
// Sequenced Kogge-Stone adder: one row of WIDTH prefix nodes is reused for
// each of the LEVELS prefix levels, one level per clock. Operands are captured
// on accept, the result is registered on the edge that applies the last level
// and held until the consumer takes it.
module iterative_prefix_adder_ctrl #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  iterative_prefix_adder_ctrl_if.slave bus
);

  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int DIST_W = LEVELS + 1;
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LEVELS - 1);

  // Reject widths the prefix schedule cannot cover.
  generate
    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0) || (LEVELS != $clog2(WIDTH))) begin : g_bad_width
      $error("iterative_prefix_adder_ctrl: WIDTH must be a power of two >= 2 and LEVELS must equal $clog2(WIDTH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  axb_s;
  logic [DIST_W-1:0] dist_s;
  logic [WIDTH-1:0]  g_row_s;
  logic [WIDTH-1:0]  p_row_s;

  assign axb_s = bus.a ^ bus.b;

  // Single shared prefix row; the level distance only steers the operand shift.
  always_comb begin
    dist_s  = DIST_W'(1) << lvl_q;
    // Nodes below the distance see Gl = 0 so G holds; P below the distance
    // sees ones shifted in so P holds as well.
    g_row_s = g_q | (p_q & (g_q << dist_s));
    p_row_s = p_q & ~((~p_q) << dist_s);
  end

  // Next-state, datapath update and result formation.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    g_d         = g_q;
    p_d         = p_q;
    h_d         = h_q;
    cin_d       = cin_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          h_d     = axb_s;
          // Bit 0 folds the carry-in into its generate, so its propagate is dead.
          p_d     = {axb_s[WIDTH-1:1], 1'b0};
          g_d     = bus.a & bus.b;
          g_d[0]  = (bus.a[0] & bus.b[0]) | (axb_s[0] & bus.cin);
          cin_d   = bus.cin;
          lvl_d   = '0;
          state_d = ST_COMPUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        g_d = g_row_s;
        p_d = p_row_s;
        if (lvl_q == LAST_LVL) begin
          lvl_d       = '0;
          state_d     = ST_DONE;
          sum_d       = h_q ^ {g_row_s[WIDTH-2:0], cin_q};
          cout_d      = g_row_s[WIDTH-1];
          out_valid_d = 1'b1;
        end else begin
          lvl_d = lvl_q + LVL_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        lvl_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lvl_q       <= '0;
      g_q         <= '0;
      p_q         <= '0;
      h_q         <= '0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      g_q         <= g_d;
      p_q         <= p_d;
      h_q         <= h_d;
      cin_q       <= cin_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
